hafsa_sopc_led_ctrl: RTL and testbench
======================================

// Module: hafsa_sopc_led_ctrl
// PURPOSE
//  Parametrised Avalon-MM LED output controller; successor to the fixed 8-bit LED PIO in the SOPC.
//  Drives WIDTH output pins, each selectable as static, blink or PWM-dimmed (PWM optional).
//  Adds bit-set/clear aliases, so software needs no read-modify-write.
//  Sits on the Nios data master as an e_avalon_slave with zero wait states; out_port goes to board LEDs.
// PARAMETERS
//  WIDTH            8             output channels, 1..16
//  DIV_W            24            blink prescaler width, bits
//  BLINK_DIV_RESET  24'd12499999  prescaler reload after reset (50 MHz: phase toggles every 250 ms)
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      word address of the register
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, combinational from address; zero read latency
//  out_port    out  WIDTH  registered LED drive
// BEHAVIOUR
//  Write = chipselect & ~write_n; takes effect at that rising edge. Reads have no side effects.
//  Register map; unused upper bits read 0; reads of addresses 6-7 return 0; writes there are ignored:
//  - 0 DATA     [WIDTH-1:0] R/W    per-channel enable (1 = lit).
//  - 1 MODE     [2*WIDTH-1:0] R/W  2 bits per channel: ch i uses bits [2i+1:2i].
//      00 static; 01 blink; 10 PWM; 11 blink AND PWM.
//  - 2 DIV      [DIV_W-1:0] R/W    prescaler reload value.
//  - 3 DUTY     [7:0] R/W          shared PWM duty.
//  - 4 OUTSET   write only; DATA |= writedata[WIDTH-1:0]; reads return DATA.
//  - 5 OUTCLEAR write only; DATA &= ~writedata[WIDTH-1:0]; reads return DATA.
//  Prescaler: pre_cnt counts up each clk.
//  - If pre_cnt == DIV: pre_cnt <= 0, tick pulses for 1 cycle, phase toggles.
//  - DIV = 0 gives a tick every cycle.
//  - Any write to DIV clears pre_cnt in the same edge; phase is held and that edge gives no tick.
//  PWM: pwm_cnt is 8 bits, free-running +1 per clk, wraps 255 -> 0.
//  - pwm_on = (pwm_cnt < DUTY). DUTY = 0 is never on; DUTY = 255 is on 255 of 256 cycles.
//  Channel value: eff_i = DATA[i] & (mode bit0 ? phase : 1) & (mode bit1 ? pwm_on : 1).
//  - out_port[i] <= eff_i, registered. A DATA write at edge N reaches out_port at edge N+1.
//  Reset (async assert, sync release), all values after reset:
//  - DATA = 0, MODE = 0, DUTY = 0, DIV = BLINK_DIV_RESET.
//  - pre_cnt = 0, phase = 0, pwm_cnt = 0, out_port = 0.
//  Reset mid-blink or mid-PWM aborts immediately; the LEDs go dark.
// CONFIGURATION
//  Macro HAFSA_LED_PWM_EN.
//  - Defined: PWM counter, DUTY register and mode bit1 gating as above.
//  - Undefined: no pwm_cnt or DUTY flops; DUTY reads 0 and writes are ignored.
//    MODE bit1 is stored and read back but treated as 1 (no gating): 10 acts as static, 11 as blink.
// STRUCTURE
//  Header hafsa_sopc_led_defs.vh holds the shared constants:
//  - register addresses ADDR_DATA..ADDR_OUTCLEAR;
//  - MODE encodings MODE_STATIC, MODE_BLINK, MODE_PWM, MODE_BLINK_PWM; PWM_W = 8.
//  Sub-module hafsa_sopc_led_tick (DIV_W): prescaler plus phase flop.
//  - Inputs: clk, reset_n, div, div_wr. Outputs: tick, phase.
//  Top level: register file, PWM counter, per-channel gating generate loop, output register.
// TESTING
//  - Reset: hold reset_n = 0 for 3 clk, release.
//    -> out_port = 0, DATA/MODE read 0, DIV reads 12499999, DUTY reads 0.
//  - Static: write DATA = 0xA5.
//    -> out_port = 0xA5 one edge later; read addr 0 = 0x000000A5.
//    Then OUTSET 0x0A gives 0xAF; OUTCLEAR 0x81 gives 0x2E.
//  - Blink: DIV = 3, DATA = 0x01, MODE = 0x1.
//    -> out_port[0] toggles every 4 clk (period 8); other bits 0.
//    A DIV write mid-period restarts the 4-clk count with no phase glitch.
//  - PWM (macro on): DUTY = 64, DATA = 0xFF, MODE = 0xAAAA.
//    -> each bit high for exactly 64 of every 256 clk.
//    DUTY = 0 gives a constant 0; DUTY = 255 gives 255/256 high.
//  - PWM (macro off): same writes as the PWM test.
//    -> out_port = 0xFF constant; DUTY reads 0; MODE reads 0xAAAA.
//  - Reset mid-op: assert reset_n during blink, asynchronously mid-cycle.
//    -> out_port = 0 before the next edge; after release, phase = 0 and DIV = reset value.

Source files
------------

// File: rtl/hafsa_sopc_led_ctrl_pkg.sv
// Purpose: shared constants for the LED controller (register map, MODE encodings, PWM width) plus the channel gate.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hafsa_sopc_led_ctrl_pkg;

    // Word addresses on the Avalon slave
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_DIV      = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Per-channel mode encodings: bit0 = blink gate, bit1 = PWM gate
    localparam logic [1:0] MODE_STATIC    = 2'b00;
    localparam logic [1:0] MODE_BLINK     = 2'b01;
    localparam logic [1:0] MODE_PWM       = 2'b10;
    localparam logic [1:0] MODE_BLINK_PWM = 2'b11;

    localparam int PWM_W = 8;

    // Gate applied on top of the channel's DATA enable
    function automatic logic led_gate(input logic [1:0] mode, input logic phase, input logic pwm_on);
        logic g;
        case (mode)
            MODE_STATIC:    g = 1'b1;
            MODE_BLINK:     g = phase;
            MODE_PWM:       g = pwm_on;
            MODE_BLINK_PWM: g = phase & pwm_on;
            default:        g = 1'b1;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hafsa_sopc_led_tick.sv
// Purpose: blink prescaler; counts to div, then pulses tick and toggles phase.
// Latency: phase toggles at the edge where pre_cnt == div; a div write restarts the count at that edge.
// Backpressure: none; free-running.
module hafsa_sopc_led_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             div_wr,
    output logic             tick,
    output logic             phase
);

    logic [DIV_W-1:0] pre_cnt;

    // A div write suppresses the terminal-count tick so the phase never glitches on reprogramming
    assign tick = (pre_cnt == div) && !div_wr;

    // Prescaler count and blink phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_wr) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            phase   <= ~phase;
        end else begin
            pre_cnt <= pre_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/hafsa_sopc_led_ctrl.sv
// Purpose: Avalon-MM LED controller, WIDTH channels of static/blink/PWM drive (PWM built only with HAFSA_LED_PWM_EN).
// Latency: zero-wait-state slave, combinational readdata; a register write reaches out_port one edge later.
// Backpressure: none; every access completes in the cycle it is presented.
module hafsa_sopc_led_ctrl
    import hafsa_sopc_led_ctrl_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DIV_W           = 24,
    parameter logic [DIV_W-1:0] BLINK_DIV_RESET = DIV_W'(12499999)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic               wr;
    logic               div_wr;
    logic [WIDTH-1:0]   data_reg;
    logic [2*WIDTH-1:0] mode_reg;
    logic [DIV_W-1:0]   div_reg;
    logic               tick;
    logic               phase;
    logic               pwm_on;
    logic [WIDTH-1:0]   eff;
    logic               unused_sink;

    assign wr     = chipselect && !write_n;
    assign div_wr = wr && (address == ADDR_DIV);

    // Register file: DATA with set/clear aliases, MODE and DIV
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            mode_reg <= '0;
            div_reg  <= BLINK_DIV_RESET;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_reg <= writedata[WIDTH-1:0];
                ADDR_MODE:     mode_reg <= writedata[2*WIDTH-1:0];
                ADDR_DIV:      div_reg  <= writedata[DIV_W-1:0];
                ADDR_OUTSET:   data_reg <= data_reg | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    hafsa_sopc_led_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (div_reg),
        .div_wr  (div_wr),
        .tick    (tick),
        .phase   (phase)
    );

`ifdef HAFSA_LED_PWM_EN
    logic [PWM_W-1:0] duty_reg;
    logic [PWM_W-1:0] pwm_cnt;

    // Shared duty register and free-running PWM counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_reg <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (wr && (address == ADDR_DUTY)) begin
                duty_reg <= writedata[PWM_W-1:0];
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty_reg);
`else
    // Without PWM hardware, the PWM gate is permanently open so MODE bit1 has no effect
    assign pwm_on = 1'b1;
`endif

    // Readback mux; alias addresses return DATA, unmapped bits and addresses return 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata[WIDTH-1:0]   = data_reg;
            ADDR_MODE:                             readdata[2*WIDTH-1:0] = mode_reg;
            ADDR_DIV:                              readdata[DIV_W-1:0]   = div_reg;
`ifdef HAFSA_LED_PWM_EN
            ADDR_DUTY:                             readdata[PWM_W-1:0]   = duty_reg;
`endif
            default:                               ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign eff[i] = data_reg[i] & led_gate(mode_reg[2*i+1 -: 2], phase, pwm_on);
    end

    // Registered LED drive; cleared asynchronously so reset darkens the board at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= eff;
        end
    end

    // Upper write-data bits and the tick strobe have no consumer at this level
    assign unused_sink = ^{writedata, tick};

endmodule

// File: tb/tb_hafsa_sopc_led_ctrl.sv
module tb_hafsa_sopc_led_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;

    hafsa_sopc_led_ctrl #(
        .WIDTH (8),
        .DIV_W (24)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out_port); end
        rd(3'd0, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", r); end
        rd(3'd1, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_mode: got %h want 0", r); end
        rd(3'd2, r);
        n_checks++;
        if (r !== 32'd12499999) begin n_fail++; $display("FAIL reset_div: got %0d want 12499999", r); end
        rd(3'd3, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL reset_duty: got %h want 0", r); end
    endtask

    task automatic test_static();
        logic [31:0] r;
        wr(3'd0, 32'h0000_00A5);
        n_checks++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL static_lat: got %h want 00", out_port); end
        @(posedge clk); #1;
        n_checks++;
        if (out_port !== 8'hA5) begin n_fail++; $display("FAIL static_out: got %h want a5", out_port); end
        rd(3'd0, r);
        n_checks++;
        if (r !== 32'h0000_00A5) begin n_fail++; $display("FAIL static_rd: got %h want a5", r); end
        wr(3'd4, 32'h0000_000A);
        @(posedge clk); #1;
        n_checks++;
        if (out_port !== 8'hAF) begin n_fail++; $display("FAIL outset_out: got %h want af", out_port); end
        rd(3'd4, r);
        n_checks++;
        if (r !== 32'h0000_00AF) begin n_fail++; $display("FAIL outset_rd: got %h want af", r); end
        wr(3'd5, 32'h0000_0081);
        @(posedge clk); #1;
        n_checks++;
        if (out_port !== 8'h2E) begin n_fail++; $display("FAIL outclr_out: got %h want 2e", out_port); end
        rd(3'd5, r);
        n_checks++;
        if (r !== 32'h0000_002E) begin n_fail++; $display("FAIL outclr_rd: got %h want 2e", r); end
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, r);
        n_checks++;
        if (r !== 32'h0000_002E) begin n_fail++; $display("FAIL unmapped_wr: got %h want 2e", r); end
        rd(3'd6, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL rd_addr6: got %h want 0", r); end
        rd(3'd7, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL rd_addr7: got %h want 0", r); end
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, r);
        n_checks++;
        if (r !== 32'h00FF_FFFF) begin n_fail++; $display("FAIL div_width: got %h want 00ffffff", r); end
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, r);
        n_checks++;
        if (r !== 32'h0000_00FF) begin n_fail++; $display("FAIL data_width: got %h want ff", r); end
        wr(3'd0, 32'd0);
    endtask

    task automatic test_blink();
        logic [7:0] exp_a [11] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        logic [7:0] exp_b [6]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h01);
        wr(3'd1, 32'h01);
        n_checks++;
        if (out_port !== 8'h01) begin n_fail++; $display("FAIL blink_start: got %h want 01", out_port); end
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_port !== exp_a[i]) begin
                n_fail++; $display("FAIL blink_seq[%0d]: got %h want %h", i, out_port, exp_a[i]);
            end
        end
        // Reprogram DIV one count into the high phase: high must stretch to 5 more edges
        wr(3'd2, 32'd3);
        n_checks++;
        if (out_port !== exp_b[0]) begin n_fail++; $display("FAIL divwr_seq[0]: got %h want %h", out_port, exp_b[0]); end
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_port !== exp_b[i]) begin
                n_fail++; $display("FAIL divwr_seq[%0d]: got %h want %h", i, out_port, exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r;
        int          waited;
        waited = 0;
        while (out_port !== 8'h01 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (out_port !== 8'h01) begin n_fail++; $display("FAIL midop_lit: got %h want 01 (timeout)", out_port); end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL midop_dark: got %h want 00", out_port); end
        n_checks++;
        if (u_dut.phase !== 1'b0) begin n_fail++; $display("FAIL midop_phase: got %b want 0", u_dut.phase); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd2, r);
        n_checks++;
        if (r !== 32'd12499999) begin n_fail++; $display("FAIL midop_div: got %0d want 12499999", r); end
        rd(3'd0, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL midop_data: got %h want 0", r); end
        rd(3'd1, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL midop_mode: got %h want 0", r); end
        n_checks++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL midop_after: got %h want 00", out_port); end
    endtask

`ifdef HAFSA_LED_PWM_EN
    task automatic test_pwm();
        logic [31:0] r;
        int          hi;
        int          bad;
        logic [7:0]  duties [3] = '{8'd64, 8'd0, 8'd255};
        int          want   [3] = '{64, 0, 255};
        wr(3'd3, 32'd64);
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'hAAAA);
        for (int k = 0; k < 3; k++) begin
            wr(3'd3, {24'd0, duties[k]});
            repeat (2) @(posedge clk);
            hi  = 0;
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                @(posedge clk); #1;
                if (out_port === 8'hFF) hi++;
                else if (out_port !== 8'h00) bad++;
            end
            n_checks++;
            if (hi !== want[k] || bad !== 0) begin
                n_fail++; $display("FAIL pwm_duty%0d: got %0d high (%0d split) want %0d", duties[k], hi, bad, want[k]);
            end
        end
        rd(3'd3, r);
        n_checks++;
        if (r !== 32'd255) begin n_fail++; $display("FAIL pwm_duty_rd: got %h want ff", r); end
        rd(3'd1, r);
        n_checks++;
        if (r !== 32'h0000_AAAA) begin n_fail++; $display("FAIL pwm_mode_rd: got %h want aaaa", r); end
    endtask
`else
    task automatic test_pwm_off();
        logic [31:0] r;
        int          bad;
        wr(3'd3, 32'd64);
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'hAAAA);
        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (out_port !== 8'hFF) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL pwmoff_out: got %0d cycles not ff want 0", bad); end
        rd(3'd3, r);
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL pwmoff_duty: got %h want 0", r); end
        rd(3'd1, r);
        n_checks++;
        if (r !== 32'h0000_AAAA) begin n_fail++; $display("FAIL pwmoff_mode: got %h want aaaa", r); end
    endtask
`endif

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_reset_midop();
`ifdef HAFSA_LED_PWM_EN
        test_pwm();
`else
        test_pwm_off();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
